data_memory_sys: RTL

DATA_MEMORY_SYS -- requirements
Module: data_memory_sys

---
 rtl/data_memory_sys.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/data_memory_sys.sv
// Data/stack memory with byte-lane load/store plus a string print engine on an independent read port.
// Loads are combinational; stores and the access-fault flag take effect at the clock edge. The engine spends 1 cycle per fetch.
// The engine holds char_valid/char_data until char_ready, so with char_ready held high it emits one character every two cycles.
// Ports: clk/rst_n; CPU port addr/wdata/mem_write/mem_read/size/sign_ext -> rdata/addr_err;
//        print port sys_start/sys_addr -> sys_busy, char_valid/char_data/char_ready handshake, sys_done/sys_err pulses.
module data_memory_sys #(
    parameter logic [31:0] DATA_BASE   = 32'h0040_0000,
    parameter int          DATA_WORDS  = 1024,
    parameter logic [31:0] STACK_BASE  = 32'hFFFF_F000,
    parameter int          STACK_WORDS = 1024,
    parameter int          MAX_STR     = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_write,
    input  logic        mem_read,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] rdata,
    output logic        addr_err,
    input  logic        sys_start,
    input  logic [31:0] sys_addr,
    output logic        sys_busy,
    output logic        char_valid,
    output logic [7:0]  char_data,
    input  logic        char_ready,
    output logic        sys_done,
    output logic        sys_err
);
    localparam int DAW = (DATA_WORDS  > 1) ? $clog2(DATA_WORDS)  : 1;
    localparam int SAW = (STACK_WORDS > 1) ? $clog2(STACK_WORDS) : 1;
    localparam int CW  = $clog2(MAX_STR + 1);
    // 64-bit bounds so a segment ending at 2^32 does not wrap the compare.
    localparam logic [63:0] DATA_LO  = {32'd0, DATA_BASE};
    localparam logic [63:0] DATA_HI  = DATA_LO + 64'(DATA_WORDS) * 64'd4;
    localparam logic [63:0] STACK_LO = {32'd0, STACK_BASE};
    localparam logic [63:0] STACK_HI = STACK_LO + 64'(STACK_WORDS) * 64'd4;

    // Zeroed at time zero; deliberately untouched by rst_n.
    logic [31:0] data_mem  [DATA_WORDS]  = '{default: '0};
    logic [31:0] stack_mem [STACK_WORDS] = '{default: '0};

    function automatic logic in_data(input logic [31:0] a);
        return ({32'd0, a} >= DATA_LO) && ({32'd0, a} < DATA_HI);
    endfunction

    function automatic logic in_stack(input logic [31:0] a);
        return ({32'd0, a} >= STACK_LO) && ({32'd0, a} < STACK_HI);
    endfunction

    function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] lane);
        case (lane)
            2'd0:    return w[7:0];
            2'd1:    return w[15:8];
            2'd2:    return w[23:16];
            default: return w[31:24];
        endcase
    endfunction

    // ---------------- CPU load/store port ----------------
    logic           cpu_data, cpu_stack, cpu_fault;
    logic [DAW-1:0] cpu_didx;
    logic [SAW-1:0] cpu_sidx;
    logic [31:0]    cpu_word, wlane;
    logic [7:0]     byte_sel;
    logic [15:0]    half_sel;
    logic [3:0]     be;

    assign cpu_data  = in_data(addr);
    assign cpu_stack = in_stack(addr);
    assign cpu_didx  = DAW'((addr - DATA_BASE) >> 2);
    assign cpu_sidx  = SAW'((addr - STACK_BASE) >> 2);
    assign cpu_fault = !(cpu_data || cpu_stack) || (size == 2'd3) ||
                       (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
    assign cpu_word  = cpu_data ? data_mem[cpu_didx] : stack_mem[cpu_sidx];
    assign byte_sel  = pick_byte(cpu_word, addr[1:0]);
    assign half_sel  = addr[1] ? cpu_word[31:16] : cpu_word[15:0];

    always_comb begin
        rdata = '0;
        be    = 4'b0000;
        wlane = wdata;
        case (size)
            2'd0: begin
                rdata = {{24{sign_ext & byte_sel[7]}}, byte_sel};
                be    = 4'b0001 << addr[1:0];
                wlane = {4{wdata[7:0]}};
            end
            2'd1: begin
                rdata = {{16{sign_ext & half_sel[15]}}, half_sel};
                be    = addr[1] ? 4'b1100 : 4'b0011;
                wlane = {2{wdata[15:0]}};
            end
            2'd2: begin
                rdata = cpu_word;
                be    = 4'b1111;
            end
            default: ;
        endcase
        if (cpu_fault) begin
            rdata = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_write && !cpu_fault) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    if (cpu_data) data_mem[cpu_didx][8*b +: 8]  <= wlane[8*b +: 8];
                    else          stack_mem[cpu_sidx][8*b +: 8] <= wlane[8*b +: 8];
                end
            end
        end
    end

    logic addr_err_d, addr_err_q;
    assign addr_err_d = (mem_read || mem_write) && cpu_fault;
    assign addr_err   = addr_err_q;

    // ---------------- Print engine ----------------
    typedef enum logic [2:0] {IDLE, FETCH, EMIT, DONE, ERR} state_t;
    state_t          state_d, state_q;
    logic [31:0]     ptr_d, ptr_q;
    logic [CW-1:0]   cnt_d, cnt_q;
    logic [7:0]      char_data_d, char_data_q;
    logic            f_data, f_stack;
    logic [31:0]     f_word;
    logic [7:0]      f_byte;

    // Independent read port; sees the pre-edge value if a store hits the same byte this cycle.
    assign f_data  = in_data(ptr_q);
    assign f_stack = in_stack(ptr_q);
    assign f_word  = f_data ? data_mem[DAW'((ptr_q - DATA_BASE) >> 2)]
                            : stack_mem[SAW'((ptr_q - STACK_BASE) >> 2)];
    assign f_byte  = pick_byte(f_word, ptr_q[1:0]);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        char_data_d = char_data_q;
        case (state_q)
            IDLE: if (sys_start) begin
                ptr_d   = sys_addr;
                cnt_d   = '0;
                state_d = FETCH;
            end
            FETCH: begin
                if (!(f_data || f_stack))  state_d = ERR;
                else if (f_byte == 8'd0)   state_d = DONE;
                else begin
                    char_data_d = f_byte;
                    state_d     = EMIT;
                end
            end
            EMIT: if (char_ready) begin
                ptr_d   = ptr_q + 32'd1;   // wraps modulo 2^32
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q + 1'b1 == CW'(MAX_STR)) ? ERR : FETCH;
            end
            default: state_d = IDLE;      // DONE / ERR last one cycle
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            char_data_q <= '0;
            addr_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            char_data_q <= char_data_d;
            addr_err_q  <= addr_err_d;
        end
    end

    assign sys_busy   = (state_q != IDLE);
    assign char_valid = (state_q == EMIT);
    assign char_data  = char_data_q;
    assign sys_done   = (state_q == DONE);
    assign sys_err    = (state_q == ERR);
endmodule
